// File: rtl/bus_timer.sv
// Memory-mapped 16-bit down-counter timer with prescaler, auto-reload and level interrupt.
// Register window of 8 bytes at BASE; reads drive the shared data bus combinationally.
module bus_timer #(
   parameter logic [15:0] BASE     = 16'hFF00,
   parameter int unsigned PRESCALE = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] addrbus,
   input  logic        rw,
   inout  wire  [7:0]  databus,
   output logic        irq
);

   localparam logic [7:0] PRE_LAST = 8'(PRESCALE - 1);

   logic        sel;
   logic        wr;
   logic [2:0]  off;
   logic        tick;
   logic [7:0]  rdata;

   logic        en;
   logic        auto;
   logic        ie;
   logic        exp;
   logic [7:0]  rld_lo;
   logic [7:0]  rld_hi;
   logic [15:0] cnt;
   logic [7:0]  pre;
   logic [7:0]  snap;

   assign sel  = (addrbus[15:3] == BASE[15:3]);
   assign off  = addrbus[2:0];
   assign wr   = sel & ~rw;
   assign tick = en && (pre == PRE_LAST);

   always_comb begin
      rdata = '0;
      case (off)
         3'd0:    rdata = {5'b0, ie, auto, en};
         3'd1:    rdata = {7'b0, exp};
         3'd2:    rdata = rld_lo;
         3'd3:    rdata = rld_hi;
         3'd4:    rdata = cnt[7:0];
         3'd5:    rdata = snap;
         default: rdata = '0;
      endcase
   end

   assign databus = (sel && rw) ? rdata : 'z;
   assign irq     = exp & ie;

   // Later assignments take priority: expiry beats W1C, CPU writes beat expiry/decrement.
   always_ff @(posedge clk) begin
      if (rst) begin
         en     <= 1'b0;
         auto   <= 1'b0;
         ie     <= 1'b0;
         exp    <= 1'b0;
         rld_lo <= '0;
         rld_hi <= '0;
         cnt    <= '0;
         pre    <= '0;
         snap   <= '0;
      end else begin
         if (!en || tick)
            pre <= '0;
         else
            pre <= pre + 8'd1;

         if (wr && off == 3'd1 && databus[0])
            exp <= 1'b0;

         if (tick) begin
            if (cnt != '0) begin
               cnt <= cnt - 16'd1;
            end else begin
               exp <= 1'b1;
               if (auto)
                  cnt <= {rld_hi, rld_lo};
               else
                  en <= 1'b0;
            end
         end

         if (wr) begin
            case (off)
               3'd0: {ie, auto, en} <= databus[2:0];
               3'd2: rld_lo <= databus;
               3'd3: begin
                  rld_hi <= databus;
                  cnt    <= {databus, rld_lo};
                  pre    <= '0;
               end
               default: ;
            endcase
         end

         if (sel && rw && off == 3'd4)
            snap <= cnt[15:8];
      end
   end

endmodule

// File: doc/bus_timer.md
BUS_TIMER -- requirements
Module: bus_timer

Interface
REQ-001 Parameter BASE, default 16'hFF00, bus address of register offset 0; it SHALL be 8-byte aligned (BASE[2:0]=0).
REQ-002 Parameter PRESCALE, default 1, clocks per counter tick, legal range 1..256.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 addrbus  input  16  CPU address bus.
REQ-006 rw  input  1  CPU bus direction: 1 = CPU read, 0 = CPU write.
REQ-007 databus  inout  8  CPU data bus; driven by this block only during a selected read, otherwise high-Z.
REQ-008 irq  output  1  interrupt request, level, active-high.

Function
REQ-009 The block SHALL be selected when addrbus[15:3] == BASE[15:3]; offset = addrbus[2:0].
REQ-010 Register map: 0 CTRL (RW; bit0 EN, bit1 AUTO, bit2 IE, bits7:3 read 0); 1 STATUS (bit0 EXP, write 1 clears, bits7:1 read 0); 2 RLD_LO (RW); 3 RLD_HI (RW); 4 CNT_LO (RO); 5 CNT_HI_SNAP (RO); 6,7 reserved, read 8'h00, writes ignored.
REQ-011 Read: while selected and rw=1, databus SHALL combinationally drive the addressed register value; zero-cycle latency.
REQ-012 Write: while selected and rw=0, databus SHALL be sampled at the rising edge and the addressed register updated at that edge; writes to RO offsets ignored.
REQ-013 Write to RLD_HI SHALL load the 16-bit counter with {new RLD_HI, RLD_LO} and clear the prescaler at the same edge.
REQ-014 Prescaler: 8-bit counter, increments each clock while EN=1; on reaching PRESCALE-1 it SHALL wrap to 0 and emit a one-cycle tick; held at 0 while EN=0.
REQ-015 On tick with counter != 0: counter decrements by 1.
REQ-016 On tick with counter == 0: EXP set to 1; if AUTO=1 counter loads {RLD_HI,RLD_LO}; if AUTO=0 counter stays 0 and EN clears to 0 at the same edge.
REQ-017 Reload value 0 with AUTO=1: EXP sets on every tick, counter remains 0.
REQ-018 Simultaneous STATUS write-1-to-clear and expiry on the same edge: EXP SHALL end 1 (set wins).
REQ-019 Simultaneous CPU write to CTRL and expiry with AUTO=0: the written CTRL value SHALL win (EN takes written bit0).
REQ-020 Simultaneous RLD_HI write and tick: the load of REQ-013 SHALL win over decrement/reload.
REQ-021 Snapshot: on every rising edge where offset 4 is selected with rw=1, CNT_HI_SNAP SHALL capture counter[15:8]; CNT_LO returns live counter[7:0].
REQ-022 irq SHALL equal EXP & IE, combinational from registered state.
REQ-023 Counter arithmetic is 16-bit unsigned; no decrement below 0.

Reset
REQ-024 While rst=1 at a rising edge: CTRL=0, EXP=0, RLD_LO=RLD_HI=0, counter=0, prescaler=0, CNT_HI_SNAP=0; irq=0 after that edge.
REQ-025 rst SHALL override any concurrent bus write or tick; a timer running mid-count SHALL stop with all state as REQ-024.
REQ-026 Bus read drive (REQ-011) is address-decoded only and is not gated by rst.

Verification
REQ-027 Reset then read offsets 0..7 at BASE=FF00 -> all return 8'h00; databus high-Z when addrbus=FF08 or rw=0.
REQ-028 PRESCALE=1: write RLD_LO=03, RLD_HI=00, CTRL=05 -> counter 3,2,1,0 on successive cycles, EXP=1 and irq=1 on the following edge, EN reads 0, counter stays 0.
REQ-029 PRESCALE=4, AUTO=1, reload 0002, EN=1 -> EXP sets every 12 clocks; write STATUS=01 on the expiry edge -> EXP stays 1; write one cycle later -> EXP=0, irq=0.
REQ-030 Counter=12FF: read offset 4 -> FF, counter decrements to 12FE, read offset 5 -> 12 (snapshot, not live); next read offset 4 refreshes snapshot.
REQ-031 Running with counter=0040, assert rst one cycle mid-count -> all registers 0, counter frozen at 0, irq=0; write RLD_HI while running -> counter reloads at that edge, prescaler restarts.
